// File: rtl/tcb_gpio_irq.sv
// TCB GPIO peripheral with atomic set/clear, byte-enable writes, an input
// synchroniser, per-bit rising/falling edge detection with sticky status and
// a level interrupt. Single TCB subordinate port, response latency 1.
module tcb_gpio_irq #(
    parameter int GW      = 32,
    parameter int ABW     = 32,
    parameter int DBW     = 32,
    parameter int CFG_CDC = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tcb_vld,
    output logic           tcb_rdy,
    input  logic           tcb_wen,
    input  logic [ABW-1:0] tcb_adr,
    input  logic [3:0]     tcb_byt,
    input  logic [DBW-1:0] tcb_wdt,
    output logic [DBW-1:0] tcb_rdt,
    output logic           tcb_err,
    output logic [GW-1:0]  gpio_o,
    output logic [GW-1:0]  gpio_e,
    input  logic [GW-1:0]  gpio_i,
    output logic           irq
);

    localparam logic [3:0] A_OUT  = 4'h0;
    localparam logic [3:0] A_ENA  = 4'h1;
    localparam logic [3:0] A_IN   = 4'h2;
    localparam logic [3:0] A_SET  = 4'h3;
    localparam logic [3:0] A_CLR  = 4'h4;
    localparam logic [3:0] A_RISE = 4'h5;
    localparam logic [3:0] A_FALL = 4'h6;
    localparam logic [3:0] A_STS  = 4'h7;

    // Edge detection is held off until the synchroniser and PRV hold real pad values.
    localparam logic [2:0] ARM_N = 3'(CFG_CDC + 1);

    logic [GW-1:0]  out_q,  out_d;
    logic [GW-1:0]  ena_q,  ena_d;
    logic [GW-1:0]  rise_q, rise_d;
    logic [GW-1:0]  fall_q, fall_d;
    logic [GW-1:0]  sts_q,  sts_d;
    logic [GW-1:0]  prv_q;
    logic [2:0]     arm_q,  arm_d;
    logic [DBW-1:0] rdt_q,  rdt_d;
    logic           err_q,  err_d;

    logic [GW-1:0]  in_s;
    logic [GW-1:0]  evt;
    logic           armed;
    logic [3:0]     idx;
    logic           unmapped;
    logic           wr;
    logic [31:0]    bmask_full;
    logic [GW-1:0]  bmask;
    logic [GW-1:0]  wbits;
    logic [GW-1:0]  wdat;
    logic [GW-1:0]  rd_val;
    logic           unused_bits;

    // Only adr[5:2] is decoded; data bits above GW are dropped.
    assign unused_bits = ^{tcb_adr, tcb_wdt};

    assign idx        = tcb_adr[5:2];
    assign unmapped   = idx[3];
    assign wr         = tcb_vld & tcb_wen;
    assign bmask_full = {{8{tcb_byt[3]}}, {8{tcb_byt[2]}}, {8{tcb_byt[1]}}, {8{tcb_byt[0]}}};
    assign bmask      = bmask_full[GW-1:0];
    assign wdat       = tcb_wdt[GW-1:0];
    assign wbits      = wdat & bmask;

    generate
        if (CFG_CDC == 0) begin : g_nosync
            assign in_s = gpio_i;
        end else begin : g_sync
            logic [GW-1:0] sync_q [CFG_CDC];
            // Synchroniser shift chain for the asynchronous pad inputs.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < CFG_CDC; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= gpio_i;
                    for (int i = 1; i < CFG_CDC; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign in_s = sync_q[CFG_CDC-1];
        end
    endgenerate

    assign armed = (arm_q == ARM_N);
    assign evt   = armed ? ((in_s & ~prv_q & rise_q) | (~in_s & prv_q & fall_q)) : '0;

    // Next-state for the control/status registers; a new event beats a W1C on the same bit.
    always_comb begin
        out_d  = out_q;
        ena_d  = ena_q;
        rise_d = rise_q;
        fall_d = fall_q;
        sts_d  = sts_q;
        arm_d  = armed ? arm_q : arm_q + 3'd1;
        if (wr) begin
            case (idx)
                A_OUT:   out_d  = (out_q  & ~bmask) | wbits;
                A_ENA:   ena_d  = (ena_q  & ~bmask) | wbits;
                A_SET:   out_d  = out_q | wbits;
                A_CLR:   out_d  = out_q & ~wbits;
                A_RISE:  rise_d = (rise_q & ~bmask) | wbits;
                A_FALL:  fall_d = (fall_q & ~bmask) | wbits;
                A_STS:   sts_d  = sts_q & ~wbits;
                default: ;
            endcase
        end
        sts_d = sts_d | evt;
    end

    // Read data multiplexer; write-only and unmapped offsets read as zero.
    always_comb begin
        rd_val = '0;
        case (idx)
            A_OUT:   rd_val = out_q;
            A_ENA:   rd_val = ena_q;
            A_IN:    rd_val = in_s;
            A_RISE:  rd_val = rise_q;
            A_FALL:  rd_val = fall_q;
            A_STS:   rd_val = sts_q;
            default: rd_val = '0;
        endcase
    end

    // Response for this transfer; writes return zero data.
    always_comb begin
        rdt_d = rdt_q;
        err_d = err_q;
        if (tcb_vld) begin
            err_d = unmapped;
            rdt_d = (tcb_wen || unmapped) ? '0 : DBW'(rd_val);
        end
    end

    // Register state; reset also discards any pending response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= '0;
            ena_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            sts_q  <= '0;
            prv_q  <= '0;
            arm_q  <= '0;
            rdt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            ena_q  <= ena_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            sts_q  <= sts_d;
            prv_q  <= in_s;
            arm_q  <= arm_d;
            rdt_q  <= rdt_d;
            err_q  <= err_d;
        end
    end

    assign tcb_rdy = 1'b1;
    assign tcb_rdt = rdt_q;
    assign tcb_err = err_q;
    assign gpio_o  = out_q;
    assign gpio_e  = ena_q;
    assign irq     = |sts_q;

endmodule
